// File: rtl/fb_scanout.sv
// 640x480@60 VGA scanout of a 320x240 12-bit frame buffer, pixel-doubled 2x2.
// Counters -> address register -> sync RAM read -> output register, 3 cycles end to end.
module fb_scanout #(
    parameter int unsigned HActive = 640,
    parameter int unsigned HFp     = 16,
    parameter int unsigned HSync   = 96,
    parameter int unsigned HBp     = 48,
    parameter int unsigned VActive = 480,
    parameter int unsigned VFp     = 10,
    parameter int unsigned VSync   = 2,
    parameter int unsigned VBp     = 33,
    parameter int unsigned FbW     = 320,
    parameter bit          SyncPol = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [16:0] o_fb_r_addr,
    output logic        o_fb_r_en,
    input  logic [11:0] i_fb_r_data,
    output logic [3:0]  o_vga_r,
    output logic [3:0]  o_vga_g,
    output logic [3:0]  o_vga_b,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic        o_vblank,
    output logic        o_frame_done
);

    localparam logic [9:0]  HLast   = 10'(HActive + HFp + HSync + HBp - 1);
    localparam logic [9:0]  VLast   = 10'(VActive + VFp + VSync + VBp - 1);
    localparam logic [9:0]  HAct    = 10'(HActive);
    localparam logic [9:0]  VAct    = 10'(VActive);
    localparam logic [9:0]  HsStart = 10'(HActive + HFp);
    localparam logic [9:0]  HsEnd   = 10'(HActive + HFp + HSync - 1);
    localparam logic [9:0]  VsStart = 10'(VActive + VFp);
    localparam logic [9:0]  VsEnd   = 10'(VActive + VFp + VSync - 1);
    localparam logic [16:0] RowStep = 17'(FbW);

    // Flag bundle carried down the pipeline: {active, hsync, vsync, vblank, frame_done}.
    localparam logic [4:0]  FlagsRst = {1'b0, ~SyncPol, ~SyncPol, 2'b00};

    logic [9:0]  h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic [16:0] row_base_q, row_base_d;
    logic [16:0] addr_q, addr_d;
    logic        en_q;
    logic [4:0]  flags_s0, flags_s1_q, flags_s2_q;
    logic        active_s0;
    logic        de_q;
    logic [11:0] rgb_q, rgb_d;
    logic        hsync_q, vsync_q, vblank_q, frame_done_q;

    // Raster counters; row_base steps once per pair of visible lines.
    always_comb begin
        h_d        = h_q + 10'd1;
        v_d        = v_q;
        row_base_d = row_base_q;
        if (h_q == HLast) begin
            h_d = '0;
            if (v_q == VLast) begin
                v_d        = '0;
                row_base_d = '0;
            end else begin
                v_d = v_q + 10'd1;
                if (v_q[0] && (v_q < VAct)) begin
                    row_base_d = row_base_q + RowStep;
                end
            end
        end
    end

    always_comb begin
        active_s0 = (h_q < HAct) && (v_q < VAct);
        flags_s0  = {
            active_s0,
            ((h_q >= HsStart) && (h_q <= HsEnd)) ? SyncPol : ~SyncPol,
            ((v_q >= VsStart) && (v_q <= VsEnd)) ? SyncPol : ~SyncPol,
            (v_q >= VAct),
            (h_q == 10'd0) && (v_q == VAct)
        };
        addr_d = active_s0 ? (row_base_q + {8'd0, h_q[9:1]}) : addr_q;
        rgb_d  = flags_s2_q[4] ? i_fb_r_data : 12'd0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h_q          <= '0;
            v_q          <= '0;
            row_base_q   <= '0;
            addr_q       <= '0;
            en_q         <= 1'b0;
            flags_s1_q   <= FlagsRst;
            flags_s2_q   <= FlagsRst;
            de_q         <= 1'b0;
            rgb_q        <= '0;
            hsync_q      <= ~SyncPol;
            vsync_q      <= ~SyncPol;
            vblank_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            h_q          <= h_d;
            v_q          <= v_d;
            row_base_q   <= row_base_d;
            addr_q       <= addr_d;
            en_q         <= active_s0;
            flags_s1_q   <= flags_s0;
            flags_s2_q   <= flags_s1_q;
            de_q         <= flags_s2_q[4];
            rgb_q        <= rgb_d;
            hsync_q      <= flags_s2_q[3];
            vsync_q      <= flags_s2_q[2];
            vblank_q     <= flags_s2_q[1];
            frame_done_q <= flags_s2_q[0];
        end
    end

    assign o_fb_r_addr  = addr_q;
    assign o_fb_r_en    = en_q;
    assign o_vga_r      = rgb_q[11:8];
    assign o_vga_g      = rgb_q[7:4];
    assign o_vga_b      = rgb_q[3:0];
    assign o_de         = de_q;
    assign o_hsync      = hsync_q;
    assign o_vsync      = vsync_q;
    assign o_vblank     = vblank_q;
    assign o_frame_done = frame_done_q;

endmodule
